pfpu_sched: RTL and testbench
=============================

PFPU_SCHED -- requirements
Module: pfpu_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning job queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning cycles allowed between start and busy rising.
REQ-003 sys_clk  in  1  single clock; all state on rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  permits dispatch of queued jobs.
REQ-006 flush  in  1  clears queued (not running) jobs.
REQ-007 job_we  in  1  push strobe for one job descriptor.
REQ-008 job_dma_base  in  29  DMA base (8-byte units).
REQ-009 job_hmesh_last / job_vmesh_last  in  7 each  mesh extents.
REQ-010 job_cp_page  in  2  program page.
REQ-011 job_full  out  1  queue full; job_level  out  clog2(DEPTH)+1  entries queued.
REQ-012 start  out  1  one-cycle PFPU start pulse.
REQ-013 busy  in  1  PFPU busy.
REQ-014 dma_base / hmesh_last / vmesh_last / cp_page  out  29/7/7/2  registered config of current job.
REQ-015 job_done  out  1  one-cycle pulse per completed job; done_count  out  16  completed jobs.
REQ-016 err_timeout  out  1  one-cycle pulse; overflow  out  1  sticky push-when-full flag; sched_busy  out  1  state not IDLE.

Function
REQ-017 Queue SHALL be a FIFO of DEPTH 45-bit descriptors {dma_base, hmesh, vmesh, page}.
REQ-018 job_we with job_full low SHALL enqueue at tail; with job_full high SHALL drop descriptor and set overflow.
REQ-019 job_full SHALL be evaluated before a same-cycle pop: push into a full queue is dropped even if a pop occurs.
REQ-020 Push into empty queue SHALL not be eligible for dispatch until the following cycle.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RUN.
REQ-022 IDLE: enable high and queue non-empty -> pop head, register config outputs, go ISSUE.
REQ-023 ISSUE: start high for exactly this cycle, timeout counter cleared, go WAIT.
REQ-024 WAIT: busy high -> RUN; counter reaching TIMEOUT-1 with busy low -> err_timeout pulse, go IDLE, no job_done.
REQ-025 RUN: busy low -> job_done pulse, done_count+1 (wraps 16'hFFFF->0), go IDLE.
REQ-026 Config outputs SHALL hold their value from pop until next pop.
REQ-027 enable low SHALL only block IDLE->ISSUE; a job in ISSUE/WAIT/RUN completes normally.
REQ-028 flush SHALL empty the queue the same cycle (job_level 0 next cycle), beat a simultaneous push and pop, and not affect FSM or config outputs.
REQ-029 Minimum dispatch-to-dispatch spacing: job_done cycle back-to-back with IDLE next cycle; new start no earlier than 2 cycles after busy falls.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 sys_rst_n low SHALL asynchronously force: FSM IDLE, queue empty, start 0, job_done 0, err_timeout 0, overflow 0, done_count 0, all config outputs 0, job_full 0, job_level 0.
REQ-032 Reset mid-job SHALL abandon the job with no job_done pulse.

Structure
REQ-033 State encoding and descriptor field widths SHALL live in shared package pfpu_pkg.
REQ-034 Queue SHALL be a sub-module pfpu_sched_fifo (sync FIFO, push/pop/flush, full/level); FSM in pfpu_sched.

Verification
REQ-035 Push 3 jobs (dma_base 0x100/0x200/0x300), enable=1, busy model high 2 cycles after start for 10 cycles -> three start pulses in order, dma_base 0x100,0x200,0x300, done_count 3.
REQ-036 Push 5 jobs with DEPTH 4, enable 0 -> job_full after 4th, 5th dropped, overflow 1, job_level 4.
REQ-037 Start with busy never asserted -> err_timeout pulse exactly 16 cycles after start, FSM IDLE, done_count unchanged.
REQ-038 Flush during RUN with 2 queued -> current job completes with job_done, job_level 0, no further start.
REQ-039 Deassert sys_rst_n during RUN -> all outputs zero immediately, no job_done after reset release.
REQ-040 done_count preset path: 65536 completions -> done_count wraps to 0.

Source files
------------

// File: rtl/pfpu_pkg.sv
// Shared types for the PFPU job scheduler: FSM state encoding and job descriptor layout.
package pfpu_pkg;

    localparam int DMA_W  = 29;
    localparam int MESH_W = 7;
    localparam int PAGE_W = 2;
    localparam int DESC_W = DMA_W + 2 * MESH_W + PAGE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RUN   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pfpu_sched_fifo.sv
// Synchronous job descriptor FIFO; flush empties it and takes priority over push and pop.
module pfpu_sched_fifo
    import pfpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DESC_W-1:0]        din,
    output logic [DESC_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DESC_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // full is the registered level, so a push into a full queue is dropped even when a pop happens
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pfpu_sched.sv
// PFPU job scheduler: queues job descriptors and dispatches them one at a time to the PFPU,
// watching for a busy handshake timeout and counting completed jobs.
module pfpu_sched
    import pfpu_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          TIMEOUT     = 16,
    parameter logic [15:0] DONE_PRESET = 16'h0000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    job_we,
    input  logic [DMA_W-1:0]        job_dma_base,
    input  logic [MESH_W-1:0]       job_hmesh_last,
    input  logic [MESH_W-1:0]       job_vmesh_last,
    input  logic [PAGE_W-1:0]       job_cp_page,
    output logic                    job_full,
    output logic [$clog2(DEPTH):0]  job_level,
    output logic                    start,
    input  logic                    busy,
    output logic [DMA_W-1:0]        dma_base,
    output logic [MESH_W-1:0]       hmesh_last,
    output logic [MESH_W-1:0]       vmesh_last,
    output logic [PAGE_W-1:0]       cp_page,
    output logic                    job_done,
    output logic [15:0]             done_count,
    output logic                    err_timeout,
    output logic                    overflow,
    output logic                    sched_busy
);

    localparam int            TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    sched_state_t      state;
    sched_state_t      next_state;
    logic              pop;
    logic              fifo_empty;
    logic [DESC_W-1:0] head;
    logic [TW-1:0]     timer;

    pfpu_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (job_we),
        .pop   (pop),
        .flush (flush),
        .din   ({job_dma_base, job_hmesh_last, job_vmesh_last, job_cp_page}),
        .dout  (head),
        .full  (job_full),
        .empty (fifo_empty),
        .level (job_level)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable && !fifo_empty) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT: begin
                if (busy)                     next_state = RUN;
                else if (timer == TIMER_LAST) next_state = IDLE;
            end
            RUN:     if (!busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A busy arriving on the last allowed WAIT cycle still wins over the timeout
    always_comb begin
        pop         = (state == IDLE) && enable && !fifo_empty;
        start       = (state == ISSUE);
        err_timeout = (state == WAIT) && !busy && (timer == TIMER_LAST);
        job_done    = (state == RUN) && !busy;
        sched_busy  = (state != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dma_base   <= '0;
            hmesh_last <= '0;
            vmesh_last <= '0;
            cp_page    <= '0;
        end else if (pop) begin
            {dma_base, hmesh_last, vmesh_last, cp_page} <= head;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer      <= '0;
            done_count <= DONE_PRESET;
            overflow   <= 1'b0;
        end else begin
            if (state == ISSUE)     timer <= '0;
            else if (state == WAIT) timer <= timer + TW'(1);
            if (job_done)           done_count <= done_count + 16'd1;
            if (job_we && job_full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pfpu_sched.sv
// Scoreboard bench for pfpu_sched: dispatch order, overflow, timeout, flush, reset and counter wrap.
module tb_pfpu_sched;
    import pfpu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        job_we = 1'b0;
    logic        busy = 1'b0;
    logic [28:0] job_dma_base = '0;
    logic [6:0]  job_hmesh_last = '0;
    logic [6:0]  job_vmesh_last = '0;
    logic [1:0]  job_cp_page = '0;
    logic        job_full, start, job_done, err_timeout, overflow, sched_busy;
    logic [2:0]  job_level;
    logic [28:0] dma_base;
    logic [6:0]  hmesh_last, vmesh_last;
    logic [1:0]  cp_page;
    logic [15:0] done_count;

    logic        w_enable = 1'b0;
    logic        w_job_we = 1'b0;
    logic        w_busy = 1'b0;
    logic        w_job_full, w_start, w_job_done, w_err_timeout, w_overflow, w_sched_busy;
    logic [2:0]  w_job_level;
    logic [28:0] w_dma_base;
    logic [6:0]  w_hmesh_last, w_vmesh_last;
    logic [1:0]  w_cp_page;
    logic [15:0] w_done_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bcnt = -1;
    bit          busy_on = 1'b0;
    logic [44:0] sb[$];
    logic [44:0] exp_desc;

    pfpu_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .flush(flush),
        .job_we(job_we), .job_dma_base(job_dma_base), .job_hmesh_last(job_hmesh_last),
        .job_vmesh_last(job_vmesh_last), .job_cp_page(job_cp_page), .job_full(job_full),
        .job_level(job_level), .start(start), .busy(busy), .dma_base(dma_base),
        .hmesh_last(hmesh_last), .vmesh_last(vmesh_last), .cp_page(cp_page),
        .job_done(job_done), .done_count(done_count), .err_timeout(err_timeout),
        .overflow(overflow), .sched_busy(sched_busy)
    );

    // Second instance starts its completion counter near the top so the wrap is reachable quickly
    pfpu_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DONE_PRESET(16'hFFFD)) dut_wrap (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(w_enable), .flush(flush),
        .job_we(w_job_we), .job_dma_base(job_dma_base), .job_hmesh_last(job_hmesh_last),
        .job_vmesh_last(job_vmesh_last), .job_cp_page(job_cp_page), .job_full(w_job_full),
        .job_level(w_job_level), .start(w_start), .busy(w_busy), .dma_base(w_dma_base),
        .hmesh_last(w_hmesh_last), .vmesh_last(w_vmesh_last), .cp_page(w_cp_page),
        .job_done(w_job_done), .done_count(w_done_count), .err_timeout(w_err_timeout),
        .overflow(w_overflow), .sched_busy(w_sched_busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // PFPU model: busy rises 2 cycles after start and stays high for 10 cycles
    always @(negedge sys_clk) begin
        if (!busy_on)      bcnt = -1;
        else if (start)    bcnt = 0;
        else if (bcnt >= 0) bcnt++;
        busy = (bcnt >= 2 && bcnt < 12);
        if (bcnt >= 12) bcnt = -1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic push_job(input logic [28:0] d, input logic [6:0] h, input logic [6:0] v,
                            input logic [1:0] pg);
        job_we = 1'b1;
        job_dma_base = d;
        job_hmesh_last = h;
        job_vmesh_last = v;
        job_cp_page = pg;
        if (sb.size() < DEPTH) sb.push_back({d, h, v, pg});
        tick();
        job_we = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({start, job_done, err_timeout, overflow, job_full, sched_busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b exp %b",
                     {start, job_done, err_timeout, overflow, job_full, sched_busy}, 6'b0);
        end
        checks++;
        if ({dma_base, hmesh_last, vmesh_last, cp_page} !== 45'd0) begin
            errors++;
            $display("[TB] FAIL reset_config got %h exp %h",
                     {dma_base, hmesh_last, vmesh_last, cp_page}, 45'd0);
        end
        checks++;
        if (done_count !== 16'd0 || job_level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_counts got %h/%0d exp 0/0", done_count, job_level);
        end
        checks++;
        if (w_done_count !== 16'hFFFD) begin
            errors++;
            $display("[TB] FAIL reset_preset got %h exp %h", w_done_count, 16'hFFFD);
        end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_three_jobs;
        int starts = 0;
        int dones = 0;
        int last_done = -1;
        busy_on = 1'b1;
        enable = 1'b0;
        push_job(29'h100, 7'd3, 7'd5, 2'd1);
        push_job(29'h200, 7'd7, 7'd2, 2'd2);
        push_job(29'h300, 7'd127, 7'd127, 2'd3);
        checks++;
        if (job_level !== 3'd3) begin
            errors++;
            $display("[TB] FAIL three_level got %0d exp 3", job_level);
        end
        enable = 1'b1;
        for (int i = 0; i < 300 && dones < 3; i++) begin
            tick();
            if (start) begin
                starts++;
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != 2) begin
                        errors++;
                        $display("[TB] FAIL spacing got %0d exp 2", cyc - last_done);
                    end
                end
                exp_desc = (sb.size() > 0) ? sb.pop_front() : 45'h1FFF_FFFF_FFFF;
                checks++;
                if ({dma_base, hmesh_last, vmesh_last, cp_page} !== exp_desc) begin
                    errors++;
                    $display("[TB] FAIL three_desc got %h exp %h",
                             {dma_base, hmesh_last, vmesh_last, cp_page}, exp_desc);
                end
            end
            if (job_done) begin
                dones++;
                last_done = cyc;
            end
        end
        tick();
        checks++;
        if (dones != 3 || starts != 3) begin
            errors++;
            $display("[TB] FAIL three_pulses got %0d/%0d exp 3/3", starts, dones);
        end
        checks++;
        if (done_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL three_count got %0d exp 3", done_count);
        end
        checks++;
        if (dma_base !== 29'h300) begin
            errors++;
            $display("[TB] FAIL config_hold got %h exp %h", dma_base, 29'h300);
        end
        enable = 1'b0;
    endtask

    task automatic test_overflow;
        busy_on = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_job(29'h10 + 29'(i), 7'd1, 7'd1, 2'd0);
        checks++;
        if (job_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_after4 got %b exp 1", job_full);
        end
        push_job(29'h99, 7'd9, 7'd9, 2'd1);
        checks++;
        if (overflow !== 1'b1 || job_level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL overflow got %b/%0d exp 1/4", overflow, job_level);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        checks++;
        if (job_level !== 3'd0 || job_full !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_sticky got %0d/%b/%b exp 0/0/1", job_level, job_full, overflow);
        end
        flush = 1'b1;
        job_we = 1'b1;
        tick();
        flush = 1'b0;
        job_we = 1'b0;
        checks++;
        if (job_level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL flush_beats_push got %0d exp 0", job_level);
        end
    endtask

    task automatic test_timeout;
        int pc;
        int sc = -1;
        int ec = -1;
        int spurious = 0;
        busy_on = 1'b0;
        enable = 1'b1;
        pc = cyc;
        push_job(29'h0ABC, 7'd4, 7'd4, 2'd2);
        if (start) sc = cyc;
        for (int i = 0; i < 20 && sc < 0; i++) begin
            tick();
            if (start) sc = cyc;
        end
        checks++;
        if (sc - pc != 2) begin
            errors++;
            $display("[TB] FAIL push_to_start got %0d exp 2", sc - pc);
        end
        exp_desc = (sb.size() > 0) ? sb.pop_front() : 45'h1FFF_FFFF_FFFF;
        checks++;
        if ({dma_base, hmesh_last, vmesh_last, cp_page} !== exp_desc) begin
            errors++;
            $display("[TB] FAIL timeout_desc got %h exp %h",
                     {dma_base, hmesh_last, vmesh_last, cp_page}, exp_desc);
        end
        for (int i = 0; i < 40 && ec < 0; i++) begin
            tick();
            if (job_done) spurious++;
            if (err_timeout) ec = cyc;
        end
        checks++;
        if (ec - sc != TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_delay got %0d exp %0d", ec - sc, TIMEOUT);
        end
        tick();
        checks++;
        if (sched_busy !== 1'b0 || err_timeout !== 1'b0 || done_count !== 16'd3 || spurious != 0) begin
            errors++;
            $display("[TB] FAIL timeout_after got %b/%b/%0d/%0d exp 0/0/3/0",
                     sched_busy, err_timeout, done_count, spurious);
        end
        enable = 1'b0;
    endtask

    task automatic test_flush_run;
        bit seen = 1'b0;
        int dones = 0;
        int extra = 0;
        busy_on = 1'b1;
        enable = 1'b0;
        push_job(29'h400, 7'd1, 7'd2, 2'd0);
        push_job(29'h500, 7'd3, 7'd4, 2'd1);
        push_job(29'h600, 7'd5, 7'd6, 2'd2);
        enable = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = start;
        end
        exp_desc = (sb.size() > 0) ? sb.pop_front() : 45'h1FFF_FFFF_FFFF;
        checks++;
        if (!seen || {dma_base, hmesh_last, vmesh_last, cp_page} !== exp_desc) begin
            errors++;
            $display("[TB] FAIL flush_desc got %h exp %h",
                     {dma_base, hmesh_last, vmesh_last, cp_page}, exp_desc);
        end
        for (int i = 0; i < 20 && !busy; i++) tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        checks++;
        if (job_level !== 3'd0 || dma_base !== 29'h400) begin
            errors++;
            $display("[TB] FAIL flush_run got %0d/%h exp 0/%h", job_level, dma_base, 29'h400);
        end
        for (int i = 0; i < 30 && dones == 0; i++) begin
            tick();
            if (job_done) dones++;
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start) extra++;
        end
        checks++;
        if (dones != 1 || extra != 0 || done_count !== 16'd4) begin
            errors++;
            $display("[TB] FAIL flush_complete got %0d/%0d/%0d exp 1/0/4", dones, extra, done_count);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_run;
        int late = 0;
        busy_on = 1'b1;
        enable = 1'b1;
        push_job(29'h700, 7'd8, 7'd8, 2'd3);
        for (int i = 0; i < 20 && !start; i++) tick();
        void'(sb.pop_front());
        for (int i = 0; i < 20 && !busy; i++) tick();
        tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({start, job_done, err_timeout, overflow, job_full, sched_busy} !== 6'b0 ||
            {dma_base, hmesh_last, vmesh_last, cp_page} !== 45'd0 ||
            done_count !== 16'd0 || job_level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got %b/%h/%0d exp 0/0/0",
                     {start, job_done, err_timeout, overflow, job_full, sched_busy},
                     {dma_base, hmesh_last, vmesh_last, cp_page}, done_count);
        end
        tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (job_done) late++;
        end
        checks++;
        if (late != 0 || done_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_abandon got %0d/%0d exp 0/0", late, done_count);
        end
        busy_on = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_wrap;
        logic [15:0] exp_w = 16'hFFFD;
        int dones = 0;
        int wb = 0;
        bit pending = 1'b0;
        w_job_we = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        w_job_we = 1'b0;
        w_enable = 1'b1;
        for (int i = 0; i < 200 && (dones < 4 || pending); i++) begin
            @(negedge sys_clk);
            if (pending) begin
                pending = 1'b0;
                checks++;
                if (w_done_count !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL wrap_count got %h exp %h", w_done_count, exp_w);
                end
            end
            if (wb > 0) begin
                w_busy = 1'b1;
                wb--;
            end else begin
                w_busy = 1'b0;
            end
            #1;
            if (w_start) wb = 1;
            if (w_job_done) begin
                dones++;
                exp_w = exp_w + 16'd1;
                pending = 1'b1;
            end
        end
        checks++;
        if (dones != 4 || w_done_count !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL wrap_final got %0d/%h exp 4/0001", dones, w_done_count);
        end
        w_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_three_jobs();
        test_overflow();
        test_timeout();
        test_flush_run();
        test_reset_run();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
